// File: rtl/pu_fetch_pkg.sv
// Shared types for the PU instruction fetch stage.
// The FIFO entry layout is fixed here; pu_fetch widths must match these defaults.
package pu_fetch_pkg;

    localparam int FETCH_PC_W   = 16;
    localparam int FETCH_INST_W = 32;

    typedef logic [1:0] fetch_state_e;

    localparam fetch_state_e FS_IDLE = 2'd0;
    localparam fetch_state_e FS_RUN  = 2'd1;
    localparam fetch_state_e FS_HALT = 2'd2;

    typedef struct packed {
        logic [FETCH_INST_W-1:0] inst;
        logic [FETCH_PC_W-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/pu_fetch_fifo.sv
// Synchronous instruction buffer of fetch entries; flush empties it in one cycle.
// Storage is not reset, only the pointers and occupancy count.
module pu_fetch_fifo
    import pu_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/pu_fetch.sv
// PU fetch stage: owns the PC, issues in-order imem requests with a reserved
// buffer slot for each one, and hands {inst, pc} to decode through a FIFO.
module pu_fetch
    import pu_fetch_pkg::*;
#(
    parameter int PC_WIDTH   = FETCH_PC_W,
    parameter int INST_WIDTH = FETCH_INST_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PC_WIDTH-1:0]   start_pc,
    input  logic                  halt,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   inst_pc,
    input  logic                  inst_ready,
    output logic                  busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

    fetch_state_e           state;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    tail_pc;
    logic [CW-1:0]          outstanding;
    logic [CW-1:0]          discard;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   redir;
    logic                   fire;
    logic                   push;
    logic                   pop;
    fetch_entry_t           push_entry;
    fetch_entry_t           head;

    assign redir = redirect_valid && (state != FS_IDLE);

    // Counting buffered plus in-flight words guarantees every response finds a free slot.
    assign imem_req  = (state == FS_RUN) && !redir && ((outstanding + fifo_count) < CW'(FIFO_DEPTH));
    assign imem_addr = pc;
    assign fire      = imem_req && imem_gnt;

    assign push       = imem_rvalid && (discard == '0) && !redir;
    assign pop        = inst_valid && inst_ready;
    assign push_entry = '{inst: imem_rdata, pc: tail_pc};

    assign inst_valid = !fifo_empty;
    assign inst       = fifo_empty ? '0 : head.inst;
    assign inst_pc    = fifo_empty ? '0 : head.pc;
    assign busy       = (state != FS_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FS_IDLE;
            pc          <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(fire) - CW'(imem_rvalid);
            if (redir)
                discard <= outstanding - CW'(imem_rvalid);
            else if (imem_rvalid && discard != '0)
                discard <= discard - CW'(1);
            if (fire) pc <= pc + PC_WIDTH'(4);
            case (state)
                FS_IDLE: begin
                    if (start) begin
                        state <= FS_RUN;
                        pc    <= start_pc & ALIGN_MASK;
                    end
                end
                default: begin
                    if (redir) begin
                        state <= FS_RUN;
                        pc    <= redirect_pc & ALIGN_MASK;
                    end else if (state == FS_RUN && halt) begin
                        state <= FS_HALT;
                    end else if (state == FS_HALT && outstanding == '0 && discard == '0) begin
                        state <= FS_IDLE;
                    end
                end
            endcase
        end
    end

    // PC of the next kept response: responses return in order, so it simply follows pushes.
    always_ff @(posedge clk) begin
        if (state == FS_IDLE && start)
            tail_pc <= start_pc & ALIGN_MASK;
        else if (redir)
            tail_pc <= redirect_pc & ALIGN_MASK;
        else if (push)
            tail_pc <= tail_pc + PC_WIDTH'(4);
    end

    pu_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redir),
        .din   (push_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    a_rvalid_has_request: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> outstanding != '0);

    a_push_has_slot: assert property (@(posedge clk) disable iff (rst)
        push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_pu_fetch.sv
// Randomized bench for pu_fetch against a transaction-level fetch model
// with an in-order imem responder of random latency.
module tb_pu_fetch;

    localparam int PW = 16;
    localparam int IW = 32;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [PW-1:0] start_pc = '0;
    logic          halt = 1'b0;
    logic          redirect_valid = 1'b0;
    logic [PW-1:0] redirect_pc = '0;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic          imem_gnt = 1'b0;
    logic          imem_rvalid = 1'b0;
    logic [IW-1:0] imem_rdata = '0;
    logic          inst_valid;
    logic [IW-1:0] inst;
    logic [PW-1:0] inst_pc;
    logic          inst_ready = 1'b0;
    logic          busy;

    always #5 clk = ~clk;

    pu_fetch #(.PC_WIDTH(PW), .INST_WIDTH(IW), .FIFO_DEPTH(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .start_pc       (start_pc),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .busy           (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: requests in flight (oldest first) and words decode should see next.
    typedef struct { logic [PW-1:0] addr; bit drop; } req_t;
    typedef struct { logic [PW-1:0] pc; logic [IW-1:0] inst; } ent_t;
    req_t          inflight[$];
    ent_t          expq[$];
    logic [PW-1:0] delivered[$];
    int            mstate = 0;   // 0 idle, 1 run, 2 halt
    logic [PW-1:0] mpc = '0;

    int gnt_pct = 0, rv_pct = 0, rdy_pct = 0, redir_pct = 0, halt_pct = 0, start_pct = 0, rst_pct = 0;
    bit            f_rst = 0, f_start = 0, f_halt = 0, f_redir = 0;
    logic [PW-1:0] f_start_pc = '0, f_redir_pc = '0;

    function automatic bit pct(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic step();
        bit   exp_req;
        bit   redir;
        bit   out_empty;
        req_t r;
        @(negedge clk);
        rst            = f_rst || pct(rst_pct);
        start          = f_start || pct(start_pct);
        start_pc       = f_start ? f_start_pc : PW'($urandom);
        halt           = f_halt || pct(halt_pct);
        redirect_valid = f_redir || pct(redir_pct);
        redirect_pc    = f_redir ? f_redir_pc : PW'($urandom);
        imem_gnt       = pct(gnt_pct);
        inst_ready     = pct(rdy_pct);
        imem_rvalid    = !rst && (inflight.size() > 0) && pct(rv_pct);
        imem_rdata     = $urandom;
        f_rst = 0; f_start = 0; f_halt = 0; f_redir = 0;
        #1;
        if (rst) begin
            inflight.delete();
            expq.delete();
            mstate = 0;
            mpc    = '0;
            return;
        end
        exp_req = (mstate == 1) && !redirect_valid && (inflight.size() + expq.size() < D);
        chk("imem_req", imem_req, exp_req);
        if (exp_req) chk("imem_addr", imem_addr, mpc);
        chk("inst_valid", inst_valid, expq.size() != 0);
        chk("busy", busy, mstate != 0);
        if (inst_valid && expq.size() != 0) begin
            chk("inst_pc", inst_pc, expq[0].pc);
            chk("inst", inst, expq[0].inst);
        end
        redir     = redirect_valid && (mstate != 0);
        out_empty = (inflight.size() == 0);
        if (inst_valid && inst_ready) begin
            delivered.push_back(inst_pc);
            if (expq.size() != 0) void'(expq.pop_front());
        end
        if (imem_rvalid) begin
            r = inflight.pop_front();
            if (!r.drop && !redir) expq.push_back('{pc: r.addr, inst: imem_rdata});
        end
        if (imem_req && imem_gnt) begin
            inflight.push_back('{addr: mpc, drop: 1'b0});
            mpc = mpc + 16'd4;
        end
        if (redir) begin
            foreach (inflight[i]) inflight[i].drop = 1'b1;
            expq.delete();
        end
        if (mstate == 0) begin
            if (start) begin
                mstate = 1;
                mpc    = start_pc & 16'hFFFC;
            end
        end else if (redir) begin
            mstate = 1;
            mpc    = redirect_pc & 16'hFFFC;
        end else if (mstate == 1 && halt) begin
            mstate = 2;
        end else if (mstate == 2 && out_empty) begin
            mstate = 0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && busy; i++) step();
        chk(tag, busy, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req"}, imem_req, 1'b0);
        chk({tag, "_addr"}, imem_addr, '0);
        chk({tag, "_valid"}, inst_valid, 1'b0);
        chk({tag, "_inst"}, inst, '0);
        chk({tag, "_pc"}, inst_pc, '0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic set_knobs(input int g, input int rv, input int rdy);
        gnt_pct = g; rv_pct = rv; rdy_pct = rdy;
        redir_pct = 0; halt_pct = 0; start_pct = 0; rst_pct = 0;
    endtask

    initial begin
        int idx;
        int n0;
        // Reset
        f_rst = 1; step();
        f_rst = 1; step();
        step();
        check_zero("reset");

        // Streaming from 0x0100 with an always-ready memory and decode
        set_knobs(100, 100, 100);
        idx = delivered.size();
        f_start = 1; f_start_pc = 16'h0100;
        run(20);
        chk("s1_count_ok", delivered.size() - idx >= 16, 1'b1);
        chk("s1_pc0", delivered[idx], 16'h0100);
        chk("s1_pc1", delivered[idx+1], 16'h0104);
        chk("s1_pc2", delivered[idx+2], 16'h0108);

        // Decode stalls: buffer fills, requests stop, then drain resumes
        set_knobs(100, 100, 0);
        run(10);
        chk("s2_req_low", imem_req, 1'b0);
        chk("s2_full", inst_valid, 1'b1);
        set_knobs(100, 100, 100);
        run(20);

        // Redirect with requests in flight and buffered words
        set_knobs(100, 30, 0);
        run(6);
        idx = delivered.size();
        f_redir = 1; f_redir_pc = 16'h0202;
        step();
        set_knobs(100, 100, 100);
        run(20);
        chk("s3_first_pc", delivered[idx], 16'h0200);

        // Redirect coinciding with a response and a pop
        run(5);
        n0 = delivered.size();
        f_redir = 1; f_redir_pc = 16'h0300;
        step();
        idx = delivered.size();
        chk("s4_pop_counted", idx - n0, 1);
        run(10);
        chk("s4_first_pc", delivered[idx], 16'h0300);

        // Halt, then PC wrap from 0xFFFC
        f_halt = 1; step();
        wait_idle("s5_idle");
        run(6);
        idx = delivered.size();
        f_start = 1; f_start_pc = 16'hFFFC;
        run(8);
        chk("s5_wrap0", delivered[idx], 16'hFFFC);
        chk("s5_wrap1", delivered[idx+1], 16'h0000);

        // Halt with outstanding requests, then reset in the middle of a run
        set_knobs(100, 0, 100);
        run(2);
        f_halt = 1; step();
        rv_pct = 100;
        wait_idle("s6_idle");
        run(6);
        chk("s6_drained", inst_valid, 1'b0);
        f_start = 1; f_start_pc = 16'h0500;
        run(5);
        f_rst = 1; step();
        step();
        check_zero("midrst");

        // Random traffic
        for (int k = 0; k < 40; k++) begin
            gnt_pct   = $urandom_range(100, 20);
            rv_pct    = $urandom_range(100, 20);
            rdy_pct   = $urandom_range(100, 10);
            redir_pct = $urandom_range(5);
            halt_pct  = $urandom_range(3);
            start_pct = 30;
            rst_pct   = (k % 10 == 9) ? 1 : 0;
            run(100);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
